bp_be_vm_fill_walker: RTL and testbench
=======================================

Name: bp_be_vm_fill_walker

Overview:
- Sv39 page-table walker that sits between the ITLB/DTLB miss paths and the memory side of the BE.
- Accepts one TLB miss at a time and issues up to three 64-bit PTE reads.
- On a valid leaf, produces the single-cycle ITLB or DTLB fill (vtag, leaf entry) that the VM trace infrastructure logs. On an invalid walk, produces a page-fault pulse instead.

Parameters:
- vaddr_width_p, 39, virtual address width; vtag_width = vaddr_width_p-12 = 27.
- paddr_width_p, 40, physical address width; ptag_width = paddr_width_p-12 = 28.
- pte_width_p, 64, PTE width in bits.
- levels_p, 3, number of page-table levels (Sv39).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- base_ppn_i  in  ptag_width  root page-table PPN (from satp)
- flush_i  in  1  abort current walk (sfence/redirect)
- miss_v_i  in  1  TLB miss request valid
- miss_itlb_i  in  1  1=ITLB miss, 0=DTLB miss
- miss_vtag_i  in  vtag_width  missing virtual tag
- ready_o  out  1  walker idle, can accept a miss
- mem_req_v_o  out  1  PTE read request valid
- mem_req_paddr_o  out  paddr_width  PTE physical address
- mem_req_ready_i  in  1  memory accepts request
- mem_resp_v_i  in  1  PTE data valid
- mem_resp_data_i  in  pte_width  PTE data
- itlb_fill_v_o  out  1  ITLB fill pulse
- dtlb_fill_v_o  out  1  DTLB fill pulse
- fill_vtag_o  out  vtag_width  vtag being filled
- fill_entry_o  out  ptag_width+7  leaf entry {ptag,d,a,g,u,x,w,r}
- fault_v_o  out  1  page-fault pulse
- fault_itlb_o  out  1  fault source (1=instruction)

Behaviour:
- Reset (async, reset_n_i low): state=IDLE, level=2. All outputs 0 except ready_o=1. Reset mid-walk abandons the walk; responses arriving afterwards are ignored.
- FSM states: IDLE, SEND, WAIT, FILL, FAULT, DRAIN.
- IDLE: ready_o=1. miss_v_i&ready_o latches vtag, itlb flag and ppn=base_ppn_i; sets level=2; moves to SEND. mem_resp_v_i is ignored.
- SEND: mem_req_v_o=1 with paddr={ppn, vpn[level], 3'b000}, truncated to paddr_width.
  - vpn2=vtag[26:18], vpn1=vtag[17:9], vpn0=vtag[8:0].
  - paddr stays stable until mem_req_ready_i. The handshake cycle moves to WAIT.
- WAIT: on mem_resp_v_i, decode V=pte[0], R=pte[1], W=pte[2], X=pte[3], ppn=pte[10 +: ptag_width].
  - V=0 or (R=0&W=1): FAULT.
  - R|X (leaf): misaligned superpage (level=2 with ppn[17:0]!=0, or level=1 with ppn[8:0]!=0) goes to FAULT. Otherwise go to FILL.
  - Non-leaf with level>0: level-1, ppn=pte ppn, SEND.
  - Non-leaf with level=0: FAULT.
- FILL (1 cycle): exactly one of itlb_fill_v_o / dtlb_fill_v_o =1.
  - ptag = pte ppn, with low 9*level bits replaced by vtag low bits (superpage splice).
  - Flags are copied from PTE bits 1..7. Next state is IDLE.
- FAULT (1 cycle): fault_v_o=1, fault_itlb_o=latched flag. Next state is IDLE.
- Fill/fault data outputs are registered and hold their last value; only the valid bits pulse.
- flush_i:
  - In SEND, go to IDLE, no request issued that cycle.
  - In WAIT, go to DRAIN; when mem_resp_v_i arrives, discard it and go to IDLE.
  - In FILL/FAULT, suppress the pulse and go to IDLE.
  - In IDLE, no effect; flush has priority over a same-cycle miss_v_i.
- Simultaneous mem_resp_v_i and flush_i in WAIT: response discarded, go to IDLE.
- Latency without backpressure: miss accepted at cycle 0 → first request cycle 1 → each level costs 1 + memory latency → fill in the cycle after the final response.
- One outstanding memory request maximum.

Decomposition:
- Shared package (bp_common_rv64_pkg):
  - Sv39 constants: page offset 12, vpn segment 9, levels 3.
  - PTE bit-position constants.
  - bp_pte_entry_leaf_s field order {ptag,d,a,g,u,x,w,r}.
  - FSM state enum bp_be_ptw_state_e.
- Sub-module bp_be_pte_decode (combinational): PTE + level → leaf/invalid/misaligned flags and spliced ptag. It is reused by the fill and fault paths.

Test Plan:
- 4K walk: base_ppn 0x80000, DTLB vtag 0x0000123.
  - Requests 0x80000000, 0x80001000, 0x80002918.
  - Responses 0x20000401, 0x20000801, 0x240000CF.
  - Result: one dtlb_fill_v_o pulse, ptag 0x90000, r=w=x=a=d=1.
- 2MB superpage: ITLB vtag 0x00201A5.
  - Requests 0x80000000 then 0x80001800.
  - Level-1 leaf ppn 0x90200, flags 0xCF.
  - Result: itlb_fill_v_o pulse with ptag 0x903A5; no third request.
- Faults:
  - Level-1 leaf ppn 0x90201 → fault_v_o pulse, no fill.
  - Leaf with V=0 → fault.
  - PTE flags W=1,R=0 → fault.
- Backpressure: mem_req_ready_i low 3 cycles → mem_req_v_o held and paddr stable; exactly one request accepted.
- Flush in WAIT: response arrives 4 cycles later → discarded, no fill/fault, ready_o=0 until drained, then 1.
- Async reset mid-walk: reset_n_i low in WAIT → outputs 0 and ready_o=1 immediately; a late mem_resp_v_i after release produces no fill.

Source files
------------

// File: rtl/bp_common_rv64_pkg.sv
// Shared Sv39 constants, PTE bit positions, leaf entry layout and walker FSM states.
package bp_common_rv64_pkg;

  localparam int page_offset_width_gp = 12;
  localparam int vpn_width_gp         = 9;
  localparam int sv39_levels_gp       = 3;
  localparam int sv39_ptag_width_gp   = 28;

  localparam int pte_v_bit_gp   = 0;
  localparam int pte_r_bit_gp   = 1;
  localparam int pte_w_bit_gp   = 2;
  localparam int pte_x_bit_gp   = 3;
  localparam int pte_u_bit_gp   = 4;
  localparam int pte_g_bit_gp   = 5;
  localparam int pte_a_bit_gp   = 6;
  localparam int pte_d_bit_gp   = 7;
  localparam int pte_ppn_lsb_gp = 10;

  // Leaf entry as handed to the TLBs; flag order mirrors PTE bits 7..1.
  typedef struct packed {
    logic [sv39_ptag_width_gp-1:0] ptag;
    logic d;
    logic a;
    logic g;
    logic u;
    logic x;
    logic w;
    logic r;
  } bp_pte_entry_leaf_s;

  typedef enum logic [2:0] {
    e_ptw_idle,
    e_ptw_send,
    e_ptw_wait,
    e_ptw_fill,
    e_ptw_fault,
    e_ptw_drain
  } bp_be_ptw_state_e;

endpackage

// File: rtl/bp_be_pte_decode.sv
// Combinational PTE classifier: validity, leaf detection, superpage alignment
// and the ptag with the untranslated low VPN bits spliced in for superpages.
module bp_be_pte_decode
  import bp_common_rv64_pkg::*;
#(
  parameter int pte_width_p  = 64,
  parameter int ptag_width_p = 28,
  parameter int vtag_width_p = 27
) (
  input  logic [pte_width_p-1:0]  pte_i,
  input  logic [1:0]              level_i,
  input  logic [vtag_width_p-1:0] vtag_i,
  output logic                    invalid_o,
  output logic                    leaf_o,
  output logic                    misaligned_o,
  output logic [ptag_width_p-1:0] ptag_o,
  output logic [6:0]              flags_o
);

  logic [ptag_width_p-1:0] ppn;
  logic unused;

  assign ppn       = pte_i[pte_ppn_lsb_gp +: ptag_width_p];
  assign invalid_o = ~pte_i[pte_v_bit_gp] | (~pte_i[pte_r_bit_gp] & pte_i[pte_w_bit_gp]);
  assign leaf_o    = pte_i[pte_r_bit_gp] | pte_i[pte_x_bit_gp];
  assign flags_o   = pte_i[pte_d_bit_gp:pte_r_bit_gp];
  assign unused    = ^{pte_i[pte_width_p-1:pte_ppn_lsb_gp+ptag_width_p],
                       pte_i[pte_ppn_lsb_gp-1:pte_d_bit_gp+1],
                       vtag_i[vtag_width_p-1:2*vpn_width_gp]};

  // Superpage handling: low 9*level PPN bits must be zero and come from the vtag.
  always_comb begin
    ptag_o       = ppn;
    misaligned_o = 1'b0;
    case (level_i)
      2'd2: begin
        misaligned_o                   = |ppn[2*vpn_width_gp-1:0];
        ptag_o[2*vpn_width_gp-1:0]     = vtag_i[2*vpn_width_gp-1:0];
      end
      2'd1: begin
        misaligned_o                   = |ppn[vpn_width_gp-1:0];
        ptag_o[vpn_width_gp-1:0]       = vtag_i[vpn_width_gp-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bp_be_vm_fill_walker.sv
// Sv39 page-table walker: one TLB miss at a time, up to three PTE reads,
// single-cycle ITLB/DTLB fill or page-fault pulse at the end.
//
//   state  | meaning
//   IDLE   | ready for a miss
//   SEND   | PTE read request presented, held until accepted
//   WAIT   | request accepted, waiting for PTE data
//   FILL   | one-cycle TLB fill pulse
//   FAULT  | one-cycle page-fault pulse
//   DRAIN  | walk flushed, discarding the in-flight response
module bp_be_vm_fill_walker
  import bp_common_rv64_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int paddr_width_p = 40,
  parameter int pte_width_p   = 64,
  parameter int levels_p      = 3,
  localparam int vtag_width_lp  = vaddr_width_p - page_offset_width_gp,
  localparam int ptag_width_lp  = paddr_width_p - page_offset_width_gp,
  localparam int entry_width_lp = ptag_width_lp + 7
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [ptag_width_lp-1:0]  base_ppn_i,
  input  logic                      flush_i,
  input  logic                      miss_v_i,
  input  logic                      miss_itlb_i,
  input  logic [vtag_width_lp-1:0]  miss_vtag_i,
  output logic                      ready_o,
  output logic                      mem_req_v_o,
  output logic [paddr_width_p-1:0]  mem_req_paddr_o,
  input  logic                      mem_req_ready_i,
  input  logic                      mem_resp_v_i,
  input  logic [pte_width_p-1:0]    mem_resp_data_i,
  output logic                      itlb_fill_v_o,
  output logic                      dtlb_fill_v_o,
  output logic [vtag_width_lp-1:0]  fill_vtag_o,
  output logic [entry_width_lp-1:0] fill_entry_o,
  output logic                      fault_v_o,
  output logic                      fault_itlb_o
);

  localparam logic [1:0] top_level_lp = 2'(levels_p - 1);

  bp_be_ptw_state_e state_q, state_d;
  logic [1:0]                level_q, level_d;
  logic [ptag_width_lp-1:0]  ppn_q, ppn_d;
  logic [vtag_width_lp-1:0]  vtag_q, vtag_d;
  logic                      itlb_q, itlb_d;
  logic [vtag_width_lp-1:0]  fill_vtag_q, fill_vtag_d;
  logic [entry_width_lp-1:0] fill_entry_q, fill_entry_d;
  logic                      fault_itlb_q, fault_itlb_d;
  logic [vpn_width_gp-1:0]   vpn;

  logic                      pte_invalid, pte_leaf, pte_misaligned;
  logic [ptag_width_lp-1:0]  pte_ptag;
  logic [6:0]                pte_flags;

  bp_be_pte_decode #(
    .pte_width_p  (pte_width_p),
    .ptag_width_p (ptag_width_lp),
    .vtag_width_p (vtag_width_lp)
  ) pte_decode (
    .pte_i        (mem_resp_data_i),
    .level_i      (level_q),
    .vtag_i       (vtag_q),
    .invalid_o    (pte_invalid),
    .leaf_o       (pte_leaf),
    .misaligned_o (pte_misaligned),
    .ptag_o       (pte_ptag),
    .flags_o      (pte_flags)
  );

  // Select the VPN segment indexing the table at the current level.
  always_comb begin
    case (level_q)
      2'd2:    vpn = vtag_q[2*vpn_width_gp +: vpn_width_gp];
      2'd1:    vpn = vtag_q[vpn_width_gp +: vpn_width_gp];
      default: vpn = vtag_q[0 +: vpn_width_gp];
    endcase
  end

  assign mem_req_paddr_o = paddr_width_p'({ppn_q, vpn, 3'b000});
  assign fill_vtag_o     = fill_vtag_q;
  assign fill_entry_o    = fill_entry_q;
  assign fault_itlb_o    = fault_itlb_q;

  // Next-state and output decode for the walk sequence.
  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    ppn_d         = ppn_q;
    vtag_d        = vtag_q;
    itlb_d        = itlb_q;
    fill_vtag_d   = fill_vtag_q;
    fill_entry_d  = fill_entry_q;
    fault_itlb_d  = fault_itlb_q;
    ready_o       = 1'b0;
    mem_req_v_o   = 1'b0;
    itlb_fill_v_o = 1'b0;
    dtlb_fill_v_o = 1'b0;
    fault_v_o     = 1'b0;
    case (state_q)
      e_ptw_idle: begin
        ready_o = 1'b1;
        if (miss_v_i && !flush_i) begin
          vtag_d  = miss_vtag_i;
          itlb_d  = miss_itlb_i;
          ppn_d   = base_ppn_i;
          level_d = top_level_lp;
          state_d = e_ptw_send;
        end
      end
      e_ptw_send: begin
        if (flush_i) begin
          state_d = e_ptw_idle;
        end else begin
          mem_req_v_o = 1'b1;
          if (mem_req_ready_i) state_d = e_ptw_wait;
        end
      end
      e_ptw_wait: begin
        if (flush_i) begin
          state_d = mem_resp_v_i ? e_ptw_idle : e_ptw_drain;
        end else if (mem_resp_v_i) begin
          if (pte_invalid || (pte_leaf && pte_misaligned) || (!pte_leaf && level_q == 2'd0)) begin
            fault_itlb_d = itlb_q;
            state_d      = e_ptw_fault;
          end else if (pte_leaf) begin
            fill_vtag_d  = vtag_q;
            fill_entry_d = {pte_ptag, pte_flags};
            state_d      = e_ptw_fill;
          end else begin
            level_d = level_q - 2'd1;
            ppn_d   = mem_resp_data_i[pte_ppn_lsb_gp +: ptag_width_lp];
            state_d = e_ptw_send;
          end
        end
      end
      e_ptw_fill: begin
        itlb_fill_v_o = !flush_i && itlb_q;
        dtlb_fill_v_o = !flush_i && !itlb_q;
        state_d       = e_ptw_idle;
      end
      e_ptw_fault: begin
        fault_v_o = !flush_i;
        state_d   = e_ptw_idle;
      end
      e_ptw_drain: begin
        if (mem_resp_v_i) state_d = e_ptw_idle;
      end
      default: state_d = e_ptw_idle;
    endcase
  end

  // State and walk context registers; async reset abandons any walk.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= e_ptw_idle;
      level_q      <= top_level_lp;
      ppn_q        <= '0;
      vtag_q       <= '0;
      itlb_q       <= 1'b0;
      fill_vtag_q  <= '0;
      fill_entry_q <= '0;
      fault_itlb_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      ppn_q        <= ppn_d;
      vtag_q       <= vtag_d;
      itlb_q       <= itlb_d;
      fill_vtag_q  <= fill_vtag_d;
      fill_entry_q <= fill_entry_d;
      fault_itlb_q <= fault_itlb_d;
    end
  end

endmodule

// File: tb/tb_bp_be_vm_fill_walker.sv
// Bench for the Sv39 fill walker: directed table, randomized walks against a
// page-table model, and hand-written flush/reset sequences.
module tb_bp_be_vm_fill_walker;
  import bp_common_rv64_pkg::*;

  typedef struct {
    logic [26:0]      vtag;
    logic             itlb;
    logic [27:0]      base;
    logic [2:0][63:0] pte;
    int               nreq;
    logic [2:0][39:0] addr;
    logic             fault;
    logic [27:0]      ptag;
    logic [6:0]       flags;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [27:0] base_ppn = '0;
  logic        flush = 1'b0;
  logic        miss_v = 1'b0;
  logic        miss_itlb = 1'b0;
  logic [26:0] miss_vtag = '0;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_v = 1'b0;
  logic [63:0] mem_resp_data = '0;
  logic        ready_o, mem_req_v_o, itlb_fill_v_o, dtlb_fill_v_o, fault_v_o, fault_itlb_o;
  logic [39:0] mem_req_paddr_o;
  logic [26:0] fill_vtag_o;
  logic [34:0] fill_entry_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] pt [logic [39:0]];
  vec_t tbl [7];

  bp_be_vm_fill_walker dut (
    .clk_i(clk), .reset_n_i(reset_n), .base_ppn_i(base_ppn), .flush_i(flush),
    .miss_v_i(miss_v), .miss_itlb_i(miss_itlb), .miss_vtag_i(miss_vtag),
    .ready_o(ready_o), .mem_req_v_o(mem_req_v_o), .mem_req_paddr_o(mem_req_paddr_o),
    .mem_req_ready_i(mem_req_ready), .mem_resp_v_i(mem_resp_v), .mem_resp_data_i(mem_resp_data),
    .itlb_fill_v_o(itlb_fill_v_o), .dtlb_fill_v_o(dtlb_fill_v_o), .fill_vtag_o(fill_vtag_o),
    .fill_entry_o(fill_entry_o), .fault_v_o(fault_v_o), .fault_itlb_o(fault_itlb_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pt_rd(input logic [39:0] a);
    return pt.exists(a) ? pt[a] : 64'd0;
  endfunction

  function automatic vec_t mk(input logic [26:0] vtag, input logic itlb, input int nreq,
                              input logic [63:0] p0, input logic [63:0] p1, input logic [63:0] p2,
                              input logic [39:0] a0, input logic [39:0] a1, input logic [39:0] a2,
                              input logic fault, input logic [27:0] ptag, input logic [6:0] flags);
    vec_t v;
    v.vtag = vtag; v.itlb = itlb; v.base = 28'h80000; v.nreq = nreq;
    v.pte[0] = p0; v.pte[1] = p1; v.pte[2] = p2;
    v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
    v.fault = fault; v.ptag = ptag; v.flags = flags;
    return v;
  endfunction

  // Reference walk straight from the Sv39 rules using integer arithmetic.
  function automatic void ref_walk(input logic [26:0] vtag, input logic [27:0] base, output vec_t e);
    longint unsigned a, addr, pte, ppn, span, vpn;
    e.vtag = vtag; e.base = base; e.itlb = 1'b0; e.nreq = 0; e.pte = '0; e.addr = '0;
    e.fault = 1'b1; e.ptag = '0; e.flags = '0;
    a = base;
    for (int i = 2; i >= 0; i--) begin
      span = 64'd1 << (9 * i);
      vpn  = (64'(vtag) / span) % 512;
      addr = a * 4096 + vpn * 8;
      e.addr[e.nreq] = addr[39:0];
      e.nreq++;
      pte = pt_rd(addr[39:0]);
      ppn = (pte >> 10) % (64'd1 << 28);
      if (pte[0] == 1'b0 || (pte[1] == 1'b0 && pte[2] == 1'b1)) return;
      if (pte[1] || pte[3]) begin
        if (ppn % span != 0) return;
        e.fault = 1'b0;
        e.ptag  = 28'(ppn + 64'(vtag) % span);
        e.flags = 7'((pte >> 1) % 128);
        return;
      end
      a = ppn;
    end
  endfunction

  // Random page-table path; the model above decides the outcome afterwards.
  task automatic gen_random_tables(input logic [26:0] vtag, input logic [27:0] base);
    longint unsigned a, addr, ppn, flags, pte, span;
    int kind;
    a = base;
    for (int i = 2; i >= 0; i--) begin
      span  = 64'd1 << (9 * i);
      addr  = a * 4096 + ((64'(vtag) >> (9 * i)) & 511) * 8;
      kind  = $urandom_range(0, 7);
      ppn   = 64'($urandom) & 64'hfffffff;
      flags = 64'($urandom) & 64'hff;
      case (kind)
        0:       pte = (ppn << 10) | (flags & 64'hfe);
        1:       pte = (ppn << 10) | ((flags & ~64'h02) | 64'h05);
        2, 3, 4: pte = (ppn << 10) | (flags & 64'hf0) | 64'h01;
        5:       pte = ((ppn - ppn % span) << 10) | flags | 64'h03;
        6:       pte = ((ppn - ppn % span) << 10) | ((flags & ~64'h06) | 64'h09);
        default: pte = (ppn << 10) | flags | 64'h03;
      endcase
      pt[addr[39:0]] = pte;
      if (kind < 2 || kind > 4) break;
      a = ppn;
    end
  endtask

  task automatic run_walk(input vec_t v, input int lat, input int bp);
    int nreq = 0, fi = 0, fd = 0, ff = 0, resp_cnt = 0, bp_left = bp;
    bit done = 0, holding = 0, stable_ok = 1, overlap = 0;
    logic [2:0][39:0] got_addr = '1;
    logic [39:0] held = '0, last_addr = '0;
    logic [26:0] got_vtag = '0;
    logic [34:0] got_entry = '0;
    logic got_fitlb = 1'b0;
    bp_pte_entry_leaf_s e;
    base_ppn = v.base;
    @(negedge clk);
    check("ready_idle", 64'(ready_o), 64'd1);
    miss_v = 1'b1; miss_itlb = v.itlb; miss_vtag = v.vtag;
    @(negedge clk);
    miss_v = 1'b0; miss_vtag = 27'($urandom); base_ppn = 28'($urandom);
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      mem_resp_v = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin mem_resp_v = 1'b1; mem_resp_data = pt_rd(last_addr); end
      end
      mem_req_ready = 1'b0;
      if (mem_req_v_o) begin
        if (resp_cnt > 0 || mem_resp_v) overlap = 1;
        if (holding && mem_req_paddr_o !== held) stable_ok = 0;
        if (bp_left > 0) begin
          bp_left--; holding = 1; held = mem_req_paddr_o;
        end else begin
          mem_req_ready = 1'b1; holding = 0;
          if (nreq < 3) got_addr[nreq] = mem_req_paddr_o;
          last_addr = mem_req_paddr_o; nreq++; resp_cnt = lat + 1;
        end
      end
      if (itlb_fill_v_o) fi++;
      if (dtlb_fill_v_o) fd++;
      if (fault_v_o) ff++;
      if (itlb_fill_v_o || dtlb_fill_v_o || fault_v_o) begin
        got_vtag = fill_vtag_o; got_entry = fill_entry_o; got_fitlb = fault_itlb_o; done = 1;
      end
      @(negedge clk);
    end
    mem_resp_v = 1'b0; mem_req_ready = 1'b0;
    check("walk_done", 64'(done), 64'd1);
    check("pulse_single", 64'({itlb_fill_v_o, dtlb_fill_v_o, fault_v_o}), 64'd0);
    check("ready_after", 64'(ready_o), 64'd1);
    check("one_outstanding", 64'(overlap), 64'd0);
    check("paddr_stable", 64'(stable_ok), 64'd1);
    check("num_requests", 64'(nreq), 64'(v.nreq));
    for (int k = 0; k < v.nreq && k < 3; k++)
      check($sformatf("req_addr%0d", k), 64'(got_addr[k]), 64'(v.addr[k]));
    if (v.fault) begin
      check("fault_count", 64'(ff), 64'd1);
      check("fill_count_on_fault", 64'(fi + fd), 64'd0);
      check("fault_itlb", 64'(got_fitlb), 64'(v.itlb));
    end else begin
      e.ptag = v.ptag;
      {e.d, e.a, e.g, e.u, e.x, e.w, e.r} = v.flags;
      check("itlb_fill_count", 64'(fi), 64'(v.itlb));
      check("dtlb_fill_count", 64'(fd), 64'(!v.itlb));
      check("fault_count_on_fill", 64'(ff), 64'd0);
      check("fill_vtag", 64'(got_vtag), 64'(v.vtag));
      check("fill_entry", 64'(got_entry), 64'(e));
    end
  endtask

  // Accept a walk with the 4K tables and stop with the DUT in WAIT.
  task automatic go_to_wait();
    base_ppn = 28'h80000;
    @(negedge clk);
    miss_v = 1'b1; miss_itlb = 1'b0; miss_vtag = 27'h123;
    @(negedge clk);
    miss_v = 1'b0;
    check("send_req_v", 64'(mem_req_v_o), 64'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("wait_not_ready", 64'(ready_o), 64'd0);
  endtask

  task automatic expect_quiet(input string name, input logic exp_ready);
    check({name, "_pulses"}, 64'({itlb_fill_v_o, dtlb_fill_v_o, fault_v_o, mem_req_v_o}), 64'd0);
    check({name, "_ready"}, 64'(ready_o), 64'(exp_ready));
  endtask

  initial begin
    vec_t v;
    tbl[0] = mk(27'h123, 0, 3, 64'h20000401, 64'h20000801, 64'h240000CF,
                40'h80000000, 40'h80001000, 40'h80002918, 0, 28'h90000, 7'h67);
    tbl[1] = mk(27'h201A5, 1, 2, 64'h20000401, 64'h240800CF, 64'h0,
                40'h80000000, 40'h80001800, 40'h0, 0, 28'h903A5, 7'h67);
    tbl[2] = mk(27'h201A5, 1, 2, 64'h20000401, 64'h240804CF, 64'h0,
                40'h80000000, 40'h80001800, 40'h0, 1, 28'h0, 7'h0);
    tbl[3] = mk(27'h123, 0, 3, 64'h20000401, 64'h20000801, 64'h240000CE,
                40'h80000000, 40'h80001000, 40'h80002918, 1, 28'h0, 7'h0);
    tbl[4] = mk(27'h123, 1, 1, 64'h00000005, 64'h0, 64'h0,
                40'h80000000, 40'h0, 40'h0, 1, 28'h0, 7'h0);
    tbl[5] = mk(27'hABCDEF, 0, 1, 64'h100000CF, 64'h0, 64'h0,
                40'h80000150, 40'h0, 40'h0, 0, 28'h7CDEF, 7'h67);
    tbl[6] = mk(27'h123, 0, 3, 64'h20000401, 64'h20000801, 64'h00000001,
                40'h80000000, 40'h80001000, 40'h80002918, 1, 28'h0, 7'h0);

    #12;
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_outputs", 64'({mem_req_v_o, itlb_fill_v_o, dtlb_fill_v_o, fault_v_o, fault_itlb_o}), 64'd0);
    check("rst_fill_data", 64'({fill_vtag_o, fill_entry_o}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int t = 0; t < 7; t++) begin
      pt.delete();
      for (int k = 0; k < tbl[t].nreq; k++) pt[tbl[t].addr[k]] = tbl[t].pte[k];
      run_walk(tbl[t], t % 3, 0);
    end

    pt.delete();
    for (int k = 0; k < 3; k++) pt[tbl[0].addr[k]] = tbl[0].pte[k];
    run_walk(tbl[0], 1, 3);

    for (int r = 0; r < 40; r++) begin
      logic [26:0] vt;
      logic [27:0] bs;
      vt = 27'($urandom);
      bs = 28'($urandom);
      pt.delete();
      gen_random_tables(vt, bs);
      ref_walk(vt, bs, v);
      v.itlb = 1'($urandom);
      run_walk(v, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Flush in WAIT: late response discarded, walker blocked until it lands.
    go_to_wait();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      expect_quiet("drain", 1'b0);
      @(negedge clk);
    end
    mem_resp_v = 1'b1; mem_resp_data = 64'h240000CF;
    @(negedge clk);
    mem_resp_v = 1'b0;
    expect_quiet("drained", 1'b1);
    @(negedge clk);
    expect_quiet("drained2", 1'b1);

    // Flush in SEND: no request that cycle, back to IDLE.
    base_ppn = 28'h80000;
    miss_v = 1'b1; miss_vtag = 27'h123;
    @(negedge clk);
    miss_v = 1'b0; flush = 1'b1; mem_req_ready = 1'b1;
    #1 check("send_flush_req", 64'(mem_req_v_o), 64'd0);
    @(negedge clk);
    flush = 1'b0; mem_req_ready = 1'b0;
    expect_quiet("send_flushed", 1'b1);

    // Flush beats a same-cycle miss in IDLE.
    flush = 1'b1; miss_v = 1'b1;
    @(negedge clk);
    flush = 1'b0; miss_v = 1'b0;
    expect_quiet("idle_flush", 1'b1);
    @(negedge clk);
    expect_quiet("idle_flush2", 1'b1);

    // Async reset in WAIT; a stray response afterwards must not fill.
    go_to_wait();
    #2 reset_n = 1'b0;
    #1;
    expect_quiet("async_rst", 1'b1);
    check("async_rst_fill_data", 64'({fill_vtag_o, fill_entry_o}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mem_resp_v = 1'b1; mem_resp_data = 64'h240000CF;
    @(negedge clk);
    mem_resp_v = 1'b0;
    for (int c = 0; c < 3; c++) begin
      expect_quiet("post_rst", 1'b1);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
